// File: rtl/swp_seq.sv
// swp_seq: register swap sequencer.
// Captures two register values and writes the swapped (full, low-half or
// high-half) results back to the register file over two consecutive cycles,
// then pulses done. Skips the writes for mode 11 or identical addresses.
//
// state | meaning
// IDLE  | waiting for start; no write
// WR_A  | writing new value to captured rs
// WR_B  | writing new value to captured rt
// FIN   | one-cycle done pulse
module swp_seq #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [AWIDTH-1:0] rs_addr,
  input  logic [AWIDTH-1:0] rt_addr,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  output logic              busy,
  output logic              done,
  output logic              rf_we,
  output logic [AWIDTH-1:0] rf_waddr,
  output logic [WIDTH-1:0]  rf_wdata,
  output logic [WIDTH-1:0]  outa,
  output logic [WIDTH-1:0]  outb
);

  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AWIDTH-1:0] cap_rs;
  logic [AWIDTH-1:0] cap_rt;
  logic [WIDTH-1:0]  new_a;
  logic [WIDTH-1:0]  new_b;
  logic              swap_ok;
  logic              accept;

  // A real swap needs a data-moving mode and two distinct registers.
  assign swap_ok = (mode != 2'b11) && (rs_addr != rt_addr);
  assign accept  = (state == IDLE) && start && swap_ok;

  // Compute swapped values from the live inputs; only used at the capture edge.
  always_comb begin
    new_a = in_a;
    new_b = in_b;
    case (mode)
      2'b00: begin
        new_a = in_b;
        new_b = in_a;
      end
      2'b01: begin
        new_a = {in_a[WIDTH-1:HALF], in_b[HALF-1:0]};
        new_b = {in_b[WIDTH-1:HALF], in_a[HALF-1:0]};
      end
      2'b10: begin
        new_a = {in_b[WIDTH-1:HALF], in_a[HALF-1:0]};
        new_b = {in_a[WIDTH-1:HALF], in_b[HALF-1:0]};
      end
      default: begin
        new_a = in_a;
        new_b = in_b;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture addresses and new values on an accepted start; held otherwise so
  // later input changes cannot disturb a swap in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_rs <= '0;
      cap_rt <= '0;
      outa   <= '0;
      outb   <= '0;
    end else if (accept) begin
      cap_rs <= rs_addr;
      cap_rt <= rt_addr;
      outa   <= new_a;
      outb   <= new_b;
    end
  end

  // Next-state logic and state-decoded outputs (outputs depend only on
  // registers, never directly on inputs).
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = swap_ok ? WR_A : FIN;
        end
      end
      WR_A: begin
        rf_we     = 1'b1;
        rf_waddr  = cap_rs;
        rf_wdata  = outa;
        state_nxt = WR_B;
      end
      WR_B: begin
        rf_we     = 1'b1;
        rf_waddr  = cap_rt;
        rf_wdata  = outb;
        state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
